// File: rtl/lcv_div_pkg.sv
// Shared types and helpers for the sequential radix-2 restoring divider.
package lcv_div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFixup,
        StDone
    } div_state_e;

    // Widest operand the helpers support; callers cast to their own width.
    localparam int unsigned MaxWidth = 64;

    localparam logic [MaxWidth-1:0] SpecQuotAllOnes = '1;

    function automatic logic [MaxWidth-1:0] twos_neg(input logic [MaxWidth-1:0] v);
        return ~v + MaxWidth'(1);
    endfunction

endpackage

// File: rtl/lcv_div_seq_if.sv
// Request/response handshake bundle for lcv_div_seq.
interface lcv_div_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             inp_valid;
    logic             inp_ready;
    logic             inp_signed;
    logic [WIDTH-1:0] inp_a;
    logic [WIDTH-1:0] inp_b;
    logic             outp_valid;
    logic             outp_ready;
    logic [WIDTH-1:0] outp_quot;
    logic [WIDTH-1:0] outp_rem;
    logic             outp_div_zero;

    modport master (
        output inp_valid, inp_signed, inp_a, inp_b, outp_ready,
        input  inp_ready, outp_valid, outp_quot, outp_rem, outp_div_zero
    );

    modport slave (
        input  inp_valid, inp_signed, inp_a, inp_b, outp_ready,
        output inp_ready, outp_valid, outp_quot, outp_rem, outp_div_zero
    );
endinterface

// File: rtl/lcv_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module lcv_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] r_next_o,
    output logic [WIDTH-1:0] q_next_o
);
    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] r_sub;
    logic           ge;

    always_comb begin
        r_shift  = {r_i, q_i[WIDTH-1]};
        r_sub    = r_shift - {1'b0, b_i};
        ge       = (r_shift >= {1'b0, b_i});
        // Remainder stays below |b|, so the top bit is always zero after the step.
        r_next_o = ge ? WIDTH'(r_sub) : WIDTH'(r_shift);
        q_next_o = {q_i[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/lcv_div_seq.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per cycle.
module lcv_div_seq
    import lcv_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    lcv_div_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             special_q, special_d;
    logic             dz_q, dz_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] step_r, step_q;
    logic             sa, sb;

    lcv_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_i      (r_q),
        .q_i      (q_q),
        .b_i      (b_q),
        .r_next_o (step_r),
        .q_next_o (step_q)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        q_d        = q_q;
        b_d        = b_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        special_d  = special_q;
        dz_d       = dz_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        div_zero_d = div_zero_q;
        sa         = bus.inp_signed & bus.inp_a[WIDTH-1];
        sb         = bus.inp_signed & bus.inp_b[WIDTH-1];

        unique case (state_q)
            StIdle: begin
                if (bus.inp_valid) begin
                    q_d       = sa ? WIDTH'(twos_neg(MaxWidth'(bus.inp_a))) : bus.inp_a;
                    b_d       = sb ? WIDTH'(twos_neg(MaxWidth'(bus.inp_b))) : bus.inp_b;
                    r_d       = '0;
                    q_neg_d   = sa ^ sb;
                    r_neg_d   = sa;
                    cnt_d     = CntW'(WIDTH - 1);
                    special_d = 1'b0;
                    dz_d      = 1'b0;
                    state_d   = StRun;
                    if (bus.inp_b == '0) begin
                        q_d       = WIDTH'(SpecQuotAllOnes);
                        r_d       = bus.inp_a;
                        special_d = 1'b1;
                        dz_d      = 1'b1;
                        state_d   = StFixup;
                    end else if (bus.inp_signed && bus.inp_a == MinVal && bus.inp_b == '1) begin
                        q_d       = MinVal;
                        r_d       = '0;
                        special_d = 1'b1;
                        state_d   = StFixup;
                    end
                end
            end
            StRun: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                if (special_q) begin
                    quot_d = q_q;
                    rem_d  = r_q;
                end else begin
                    quot_d = q_neg_q ? WIDTH'(twos_neg(MaxWidth'(q_q))) : q_q;
                    rem_d  = r_neg_q ? WIDTH'(twos_neg(MaxWidth'(r_q))) : r_q;
                end
                div_zero_d = dz_q;
                state_d    = StDone;
            end
            StDone: begin
                if (bus.outp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Handshake flags follow the next state so they are registered yet in step with it.
        ready_d = (state_d == StIdle);
        valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            r_q        <= '0;
            q_q        <= '0;
            b_q        <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            special_q  <= 1'b0;
            dz_q       <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            q_q        <= q_d;
            b_q        <= b_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            special_q  <= special_d;
            dz_q       <= dz_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.inp_ready     = ready_q;
    assign bus.outp_valid    = valid_q;
    assign bus.outp_quot     = quot_q;
    assign bus.outp_rem      = rem_q;
    assign bus.outp_div_zero = div_zero_q;

endmodule

// File: doc/lcv_div_seq.md
# lcv_div_seq

Multi-cycle radix-2 restoring integer divider, the inverse-direction companion to the LcvMulAcc/ALU arithmetic blocks. It accepts one signed or unsigned dividend/divisor pair over a valid/ready handshake and iterates one quotient bit per cycle. It returns quotient and remainder over a second valid/ready handshake. It serves as the DIV/REM unit beside the single-cycle ALU and does not use DSP inference.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- clk  input  1  sole clock; all state changes on posedge.
- rst  input  1  synchronous, active-low reset (asserted when 0).
- inp_valid  input  1  request valid.
- inp_ready  output  1  block can accept a request.
- inp_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- inp_a  input  WIDTH  dividend.
- inp_b  input  WIDTH  divisor.
- outp_valid  output  1  result valid.
- outp_ready  input  1  consumer accepts result.
- outp_quot  output  WIDTH  quotient.
- outp_rem  output  WIDTH  remainder.
- outp_div_zero  output  1  divisor was zero.

## Operation
- Operation uses four states: IDLE, RUN, FIXUP and DONE.
- **IDLE**
  - inp_ready=1.
  - On inp_valid&inp_ready, the block latches the operands.
  - When signed, it stores |a| and |b| as magnitudes, q_neg = a[MSB]^b[MSB], and r_neg = a[MSB]. Magnitude of MIN equals 2^(WIDTH-1), held unsigned.
- **Special cases** (decided at accept, RUN is skipped, next state is FIXUP):
  - b==0: quot = all ones, rem = a, div_zero=1, no sign fixup.
  - signed a==MIN and b==-1: quot = MIN, rem = 0.
- **RUN**
  - Iteration counter counts WIDTH-1 down to 0.
  - Each cycle:
    - Partial remainder is WIDTH+1 bits.
    - r' = {r, q[MSB]}.
    - Shift q left.
    - If r' ≥ |b|, then r = r' − |b| and q[0] = 1; else r = r' and q[0] = 0.
  - When the counter reaches 0, next state is FIXUP.
- **FIXUP** (one cycle)
  - If q_neg, negate q. If r_neg, negate r. Both are truncated to WIDTH.
  - Special-case results pass through unchanged.
  - Next state is DONE.
- **DONE**
  - outp_valid=1; outputs are stable.
  - On outp_ready, next state is IDLE.
- inp_ready is 0 in every state except IDLE. There is no request overlap.
- Unsigned mode ignores sign bits entirely.
- Remainder carries the dividend sign; quotient truncates toward zero.

## Timing
- **Reset values:**
  - state=IDLE, inp_ready=1 (the cycle after reset deasserts).
  - outp_valid=0, outp_quot=0, outp_rem=0, outp_div_zero=0.
  - Counter and internal registers are 0.
- **Normal latency:** accept at edge T, then RUN on edges T+1..T+WIDTH, then FIXUP on edge T+WIDTH+1. outp_valid=1 from cycle T+WIDTH+2.
- **Special-case latency:** outp_valid=1 from cycle T+2.
- **Back-pressure:** outp_valid stays 1 and all outputs stay constant until outp_ready=1 on a clock edge.
- **Throughput:** inp_ready returns to 1 one cycle after the output handshake. inp_valid held during DONE is not accepted until IDLE.
- **Reset mid-operation:**
  - Any state returns to IDLE on the next edge and the in-flight result is discarded.
  - outp_valid=0 on that edge.
- outp_valid and inp_ready are never both 1.

## Structure
- Package lcv_div_pkg holds:
  - the state enum (IDLE, RUN, FIXUP, DONE);
  - a helper function for the two's-complement negate;
  - the special-case quotient constant (all ones).
- Sub-module lcv_div_step is purely combinational and implements one restoring iteration.
  - Inputs are r, q and |b|; outputs are r_next and q_next.
  - It is parameterised by WIDTH.
- The top level contains the FSM, counter, operand registers and fixup.

## Test plan
- **Unsigned divide:**
  - Stimulus: inp_signed=0, a=100, b=7, outp_ready=1.
  - Required: quot=14, rem=2, div_zero=0, with outp_valid first seen WIDTH+2 cycles after accept.
- **Signed divide:**
  - Stimulus: a=-7, b=2.
  - Required: quot=-3, rem=-1. Also a=7, b=-2 gives quot=-3, rem=1.
- **Divide by zero:**
  - Stimulus: a=0x1234, b=0, either mode.
  - Required: quot=0xFFFFFFFF, rem=0x1234, div_zero=1, with outp_valid at accept+2.
- **Signed overflow:**
  - Stimulus: a=0x80000000, b=0xFFFFFFFF, signed.
  - Required: quot=0x80000000, rem=0, at accept+2.
  - The same operands unsigned give quot=0, rem=0x80000000 at full latency.
- **Back-pressure:**
  - Stimulus: outp_ready=0 for 5 cycles after outp_valid rises, with inp_valid held high.
  - Required: outputs stable and inp_ready=0 throughout. Handshake completes, and the next request is accepted exactly one cycle later.
- **Reset mid-operation:**
  - Stimulus: assert rst=0 for one cycle midway through RUN.
  - Required: next cycle has outp_valid=0, inp_ready=1 and all outputs 0. A following request 200/10 yields quot=20, rem=0.
